// File: rtl/layer_pkg.sv
// Shared types and elaboration-time helpers for the layer stream block.
package layer_pkg;

  typedef enum logic {IDLE, SHIFT} state_t;

  function automatic int idx_w(input int nn);
    return (nn > 1) ? $clog2(nn) : 1;
  endfunction

  function automatic logic [127:0] append_num(input logic [127:0] s_in, input int v);
    logic [127:0] s;
    s = s_in;
    for (int p = 1000000000; p >= 1; p = p / 10) begin
      if (v >= p || p == 1) s = {s[119:0], 8'(8'd48 + 8'((v / p) % 10))};
    end
    return s;
  endfunction

  // Builds "<kind>_<layer>_<n>.mem", right-aligned in a 16-character string.
  function automatic logic [127:0] mem_name(input logic [7:0] kind, input int layer, input int n);
    logic [127:0] s;
    s = {120'd0, kind};
    s = {s[119:0], 8'h5f};
    s = append_num(s, layer);
    s = {s[119:0], 8'h5f};
    s = append_num(s, n);
    s = {s[95:0], ".mem"};
    return s;
  endfunction

endpackage

// File: rtl/layer_serializer.sv
// Captures a parallel layer result into a double buffer and streams it out word by word.
//   state | meaning
//   IDLE  | nothing to send, waiting for a capture
//   SHIFT | presenting buf_q[idx] with s_valid high
module layer_serializer
  import layer_pkg::*;
#(
  parameter int NN = 10,
  parameter int dataWidth = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cap,
  input  logic [NN*dataWidth-1:0] din,
  input  logic                    s_ready,
  output logic [dataWidth-1:0]    s_data,
  output logic                    s_valid,
  output logic                    s_last,
  output logic                    overrun
);
  localparam int IW = idx_w(NN);
  localparam logic [IW-1:0] LAST = IW'(NN - 1);

  state_t               state, state_nxt;
  logic [dataWidth-1:0] buf_q  [NN];
  logic [dataWidth-1:0] pend_q [NN];
  logic                 pend_full;
  logic [IW-1:0]        idx;
  logic                 hs, at_last;
  logic                 load_x, load_p, idx_inc, idx_clr, pend_wr, pend_clr, ovf_set;

  assign at_last = (idx == LAST);
  assign hs      = (state == SHIFT) && s_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_x    = 1'b0;
    load_p    = 1'b0;
    idx_inc   = 1'b0;
    idx_clr   = 1'b0;
    pend_wr   = 1'b0;
    pend_clr  = 1'b0;
    ovf_set   = 1'b0;
    case (state)
      IDLE: begin
        if (cap) begin
          state_nxt = SHIFT;
          load_x    = 1'b1;
          idx_clr   = 1'b1;
        end
      end
      SHIFT: begin
        if (hs && at_last) begin
          idx_clr = 1'b1;
          if (pend_full) begin
            load_p   = 1'b1;
            pend_clr = 1'b1;
          end else if (cap) begin
            load_x = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else if (hs) begin
          idx_inc = 1'b1;
        end
        // A capture not absorbed by the final handshake judges room on the current pend_full.
        if (cap && !(hs && at_last && !pend_full)) begin
          if (pend_full) ovf_set = 1'b1;
          else           pend_wr = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int n = 0; n < NN; n++) begin
        buf_q[n]  <= '0;
        pend_q[n] <= '0;
      end
      pend_full <= 1'b0;
      idx       <= '0;
      overrun   <= 1'b0;
    end else begin
      if (load_x) begin
        for (int n = 0; n < NN; n++) buf_q[n] <= din[n*dataWidth +: dataWidth];
      end else if (load_p) begin
        for (int n = 0; n < NN; n++) buf_q[n] <= pend_q[n];
      end
      if (pend_wr) begin
        for (int n = 0; n < NN; n++) pend_q[n] <= din[n*dataWidth +: dataWidth];
      end
      if (pend_wr)       pend_full <= 1'b1;
      else if (pend_clr) pend_full <= 1'b0;
      if (idx_clr)       idx <= '0;
      else if (idx_inc)  idx <= idx + IW'(1);
      if (ovf_set)       overrun <= 1'b1;
    end
  end

  always_comb begin
    s_valid = (state == SHIFT);
    s_last  = s_valid && at_last;
    s_data  = s_valid ? buf_q[idx] : '0;
  end

endmodule

// File: rtl/neuron.sv
// Lightweight neuron stand-in with the full neuron interface: sums one frame of
// numWeight inputs and presents (sum - neuronNo) with a one-cycle outvalid.
module neuron #(
  parameter int numWeight = 784,
  parameter int layerNo = 0,
  parameter int neuronNo = 0,
  parameter int dataWidth = 16,
  parameter int sigmoidSize = 10,
  parameter int weightIntWidth = 4,
  parameter actType = "relu",
  parameter logic [127:0] biasFile = '0,
  parameter logic [127:0] weightFile = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [dataWidth-1:0] myinput,
  input  logic                 myinputValid,
  input  logic                 weightValid,
  input  logic                 biasValid,
  input  logic [31:0]          weightValue,
  input  logic [31:0]          biasValue,
  input  logic [31:0]          config_layer_num,
  input  logic [31:0]          config_neuron_num,
  output logic [dataWidth-1:0] out,
  output logic                 outvalid
);
  localparam int CW = (numWeight > 1) ? $clog2(numWeight) : 1;

  logic [CW-1:0]        cnt;
  logic [dataWidth-1:0] acc;
  logic                 unused_cfg;

  assign unused_cfg = ^{weightValid, biasValid, weightValue, biasValue, config_layer_num,
                        config_neuron_num, weightFile, biasFile, actType, 32'(layerNo),
                        32'(sigmoidSize), 32'(weightIntWidth)};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      acc      <= '0;
      out      <= '0;
      outvalid <= 1'b0;
    end else begin
      outvalid <= 1'b0;
      if (myinputValid) begin
        if (cnt == CW'(numWeight - 1)) begin
          cnt      <= '0;
          acc      <= '0;
          out      <= acc + myinput - dataWidth'(neuronNo);
          outvalid <= 1'b1;
        end else begin
          cnt <= cnt + CW'(1);
          acc <= acc + myinput;
        end
      end
    end
  end

endmodule

// File: rtl/layer_stream.sv
// Fully-connected layer: NN neurons on one shared input stream, results re-serialised
// into a valid/ready word stream for the next layer.
module layer_stream
  import layer_pkg::*;
#(
  parameter int NN = 10,
  parameter int numWeight = 784,
  parameter int dataWidth = 16,
  parameter int layerNum = 1,
  parameter int sigmoidSize = 10,
  parameter int weightIntWidth = 4,
  parameter actType = "relu"
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    weightValid,
  input  logic                    biasValid,
  input  logic [31:0]             weightValue,
  input  logic [31:0]             biasValue,
  input  logic [31:0]             config_layer_num,
  input  logic [31:0]             config_neuron_num,
  input  logic                    x_valid,
  input  logic [dataWidth-1:0]    x_in,
  output logic [NN-1:0]           o_valid,
  output logic [NN*dataWidth-1:0] x_out,
  output logic [dataWidth-1:0]    s_data,
  output logic                    s_valid,
  input  logic                    s_ready,
  output logic                    s_last,
  output logic                    overrun
);
  logic neuron_rst;
  logic cap;

  // Neurons use an active-high reset.
  assign neuron_rst = ~rst;
  assign cap        = &o_valid;

  for (genvar n = 0; n < NN; n++) begin : g_neuron
    localparam logic [127:0] W_FILE = mem_name("w", layerNum, n);
    localparam logic [127:0] B_FILE = mem_name("b", layerNum, n);

    neuron #(
      .numWeight(numWeight),
      .layerNo(layerNum),
      .neuronNo(n),
      .dataWidth(dataWidth),
      .sigmoidSize(sigmoidSize),
      .weightIntWidth(weightIntWidth),
      .actType(actType),
      .biasFile(B_FILE),
      .weightFile(W_FILE)
    ) u_neuron (
      .clk(clk),
      .rst(neuron_rst),
      .myinput(x_in),
      .myinputValid(x_valid),
      .weightValid(weightValid),
      .biasValid(biasValid),
      .weightValue(weightValue),
      .biasValue(biasValue),
      .config_layer_num(config_layer_num),
      .config_neuron_num(config_neuron_num),
      .out(x_out[n*dataWidth +: dataWidth]),
      .outvalid(o_valid[n])
    );
  end

  layer_serializer #(
    .NN(NN),
    .dataWidth(dataWidth)
  ) u_serializer (
    .clk(clk),
    .rst(rst),
    .cap(cap),
    .din(x_out),
    .s_ready(s_ready),
    .s_data(s_data),
    .s_valid(s_valid),
    .s_last(s_last),
    .overrun(overrun)
  );

endmodule

// File: tb/tb_layer_stream.sv
// Self-checking bench for layer_stream: per-cycle frame-queue reference model plus scenario checks.
module tb_layer_stream;
  localparam int NN = 4;
  localparam int NW = 4;
  localparam int DW = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              weightValid = 1'b0, biasValid = 1'b0;
  logic [31:0]       weightValue = '0, biasValue = '0;
  logic [31:0]       config_layer_num = '0, config_neuron_num = '0;
  logic              x_valid = 1'b0;
  logic [DW-1:0]     x_in = '0;
  logic [NN-1:0]     o_valid;
  logic [NN*DW-1:0]  x_out;
  logic [DW-1:0]     s_data;
  logic              s_valid, s_ready = 1'b0, s_last, overrun;

  always #5 clk = ~clk;

  layer_stream #(
    .NN(NN), .numWeight(NW), .dataWidth(DW), .layerNum(1),
    .sigmoidSize(10), .weightIntWidth(4), .actType("relu")
  ) dut (
    .clk(clk), .rst(rst),
    .weightValid(weightValid), .biasValid(biasValid),
    .weightValue(weightValue), .biasValue(biasValue),
    .config_layer_num(config_layer_num), .config_neuron_num(config_neuron_num),
    .x_valid(x_valid), .x_in(x_in),
    .o_valid(o_valid), .x_out(x_out),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .s_last(s_last), .overrun(overrun)
  );

  int checks = 0;
  int fails = 0;
  int cyc = 0;

  // Reference model: frames waiting to be emitted, as word queues.
  logic [DW-1:0] cur[$];
  logic [DW-1:0] pend[$];
  logic          m_ovr = 1'b0;
  logic          cap_now = 1'b0;
  logic [DW-1:0] cap_frame[NN];
  logic [DW-1:0] acc = '0;
  int            cnt = 0;

  logic          exp_valid, exp_last, exp_ovr, exp_cap;
  logic [DW-1:0] exp_data;
  logic          obs_valid, obs_last, obs_ovr, obs_cap, obs_mixed;
  logic [DW-1:0] obs_data;

  function automatic string cyc_str();
    return $sformatf("cyc=%0d got v=%b d=%h l=%b ov=%b cap=%b mixed=%b, want v=%b d=%h l=%b ov=%b cap=%b mixed=0",
                     cyc, obs_valid, obs_data, obs_last, obs_ovr, obs_cap, obs_mixed,
                     exp_valid, exp_data, exp_last, exp_ovr, exp_cap);
  endfunction

  task automatic model_reset();
    cur = {};
    pend = {};
    m_ovr = 1'b0;
    cap_now = 1'b0;
    acc = '0;
    cnt = 0;
  endtask

  // One clock: drive, sample at negedge, advance model at posedge; returns at posedge+1.
  task automatic cycle(input logic xv, input logic [DW-1:0] xd, input logic rdy);
    bit was_idle, old_pend, hs, consumed;
    x_valid = xv;
    x_in    = xd;
    s_ready = rdy;
    exp_valid = (cur.size() != 0);
    exp_data  = exp_valid ? cur[0] : '0;
    exp_last  = (cur.size() == 1);
    exp_ovr   = m_ovr;
    exp_cap   = cap_now;
    @(negedge clk);
    obs_valid = s_valid;
    obs_data  = s_data;
    obs_last  = s_last;
    obs_ovr   = overrun;
    obs_cap   = &o_valid;
    obs_mixed = (o_valid != '0) && !(&o_valid);
    @(posedge clk);
    was_idle = (cur.size() == 0);
    old_pend = (pend.size() != 0);
    hs = !was_idle && rdy;
    consumed = 1'b0;
    if (hs) begin
      void'(cur.pop_front());
      if (cur.size() == 0) begin
        if (old_pend) begin
          cur = pend;
          pend = {};
        end else if (cap_now) begin
          for (int n = 0; n < NN; n++) cur.push_back(cap_frame[n]);
          consumed = 1'b1;
        end
      end
    end
    if (cap_now && !consumed) begin
      if (was_idle) begin
        for (int n = 0; n < NN; n++) cur.push_back(cap_frame[n]);
      end else if (!old_pend) begin
        for (int n = 0; n < NN; n++) pend.push_back(cap_frame[n]);
      end else begin
        m_ovr = 1'b1;
      end
    end
    cap_now = 1'b0;
    if (xv) begin
      if (cnt == NW - 1) begin
        for (int n = 0; n < NN; n++) cap_frame[n] = DW'(acc + xd - DW'(n));
        cap_now = 1'b1;
        cnt = 0;
        acc = '0;
      end else begin
        acc = DW'(acc + xd);
        cnt++;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (s_valid !== 1'b0) begin fails++; $display("FAIL reset_s_valid got %b want 0", s_valid); end
    checks++; if (s_last !== 1'b0) begin fails++; $display("FAIL reset_s_last got %b want 0", s_last); end
    checks++; if (s_data !== '0) begin fails++; $display("FAIL reset_s_data got %h want 0000", s_data); end
    checks++; if (overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun got %b want 0", overrun); end
    checks++; if (o_valid !== '0) begin fails++; $display("FAIL reset_o_valid got %b want 0000", o_valid); end
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_single_frame();
    logic [DW-1:0] want[4];
    logic [DW-1:0] got[$];
    int cap_c = -1, first_v = -1, last_at = -1, last_cnt = 0;
    bit ok;
    want = '{16'h0004, 16'h0003, 16'h0002, 16'h0001};
    for (int i = 0; i < 12; i++) begin
      cycle(i < 4, 16'h0001, 1'b1);
      checks++;
      if (obs_valid !== exp_valid || obs_last !== exp_last || obs_ovr !== exp_ovr || obs_cap !== exp_cap ||
          obs_mixed !== 1'b0 || (exp_valid && obs_data !== exp_data)) begin
        fails++; $display("FAIL single_frame %s", cyc_str());
      end
      if (obs_cap && cap_c < 0) cap_c = i;
      if (obs_valid && first_v < 0) first_v = i;
      if (obs_valid) got.push_back(obs_data);
      if (obs_last) begin last_at = got.size(); last_cnt++; end
    end
    ok = (got.size() == 4);
    for (int i = 0; i < 4; i++) if (ok && got[i] !== want[i]) ok = 1'b0;
    checks++; if (!ok) begin fails++; $display("FAIL single_words got %p want 4,3,2,1", got); end
    checks++; if (cap_c < 0 || first_v != cap_c + 1) begin
      fails++; $display("FAIL single_latency got first valid cycle %0d want %0d", first_v, cap_c + 1);
    end
    checks++; if (last_at != 4 || last_cnt != 1) begin
      fails++; $display("FAIL single_last got at word %0d count %0d want word 4 count 1", last_at, last_cnt);
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] got[$];
    int stall = 0;
    logic rdy;
    for (int i = 0; i < 16; i++) begin
      rdy = 1'b1;
      if (cur.size() == 3 && stall < 3) begin rdy = 1'b0; stall++; end
      cycle(i < 4, 16'h0001, rdy);
      checks++;
      if (obs_valid !== exp_valid || obs_last !== exp_last || obs_ovr !== exp_ovr || obs_cap !== exp_cap ||
          obs_mixed !== 1'b0 || (exp_valid && obs_data !== exp_data)) begin
        fails++; $display("FAIL backpressure %s", cyc_str());
      end
      if (!rdy) begin
        checks++;
        if (obs_valid !== 1'b1 || obs_data !== 16'h0003) begin
          fails++; $display("FAIL bp_hold got v=%b d=%h want v=1 d=0003", obs_valid, obs_data);
        end
      end
      if (obs_valid && rdy) got.push_back(obs_data);
    end
    checks++;
    if (stall != 3 || got.size() != 4 || got[0] !== 16'h4 || got[1] !== 16'h3 || got[2] !== 16'h2 || got[3] !== 16'h1) begin
      fails++; $display("FAIL bp_order got %p stalls %0d want 4,3,2,1 stalls 3", got, stall);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] w[8];
    logic [DW-1:0] got[$];
    logic [DW-1:0] sum_a = '0, sum_b = '0;
    int bubbles = 0;
    bit stalled = 1'b0, ok;
    logic rdy;
    for (int i = 0; i < 8; i++) w[i] = DW'($urandom);
    for (int i = 0; i < 4; i++) begin sum_a += w[i]; sum_b += w[i+4]; end
    for (int i = 0; i < 20; i++) begin
      rdy = 1'b1;
      if (cur.size() == 4 && !stalled) begin rdy = 1'b0; stalled = 1'b1; end
      cycle(i < 8, (i < 8) ? w[i % 8] : '0, rdy);
      checks++;
      if (obs_valid !== exp_valid || obs_last !== exp_last || obs_ovr !== exp_ovr || obs_cap !== exp_cap ||
          obs_mixed !== 1'b0 || (exp_valid && obs_data !== exp_data)) begin
        fails++; $display("FAIL back_to_back %s", cyc_str());
      end
      if (got.size() > 0 && got.size() < 8 && !obs_valid) bubbles++;
      if (obs_valid && rdy) got.push_back(obs_data);
    end
    ok = (got.size() == 8);
    for (int k = 0; k < 8; k++)
      if (ok && got[k] !== ((k < 4) ? DW'(sum_a - DW'(k)) : DW'(sum_b - DW'(k - 4)))) ok = 1'b0;
    checks++; if (!ok) begin fails++; $display("FAIL b2b_words got %p want A sum %h then B sum %h minus index", got, sum_a, sum_b); end
    checks++; if (bubbles != 0) begin fails++; $display("FAIL b2b_bubble got %0d idle cycles want 0", bubbles); end
  endtask

  task automatic test_overrun();
    logic [DW-1:0] w[12];
    logic [DW-1:0] got[$];
    logic [DW-1:0] sum_a = '0, sum_b = '0;
    int caps = 0, c3 = -1, rise = -1;
    bit ok;
    for (int i = 0; i < 12; i++) w[i] = DW'($urandom);
    for (int i = 0; i < 4; i++) begin sum_a += w[i]; sum_b += w[i+4]; end
    for (int i = 0; i < 36; i++) begin
      cycle(i < 12, (i < 12) ? w[i % 12] : '0, i >= 16);
      checks++;
      if (obs_valid !== exp_valid || obs_last !== exp_last || obs_ovr !== exp_ovr || obs_cap !== exp_cap ||
          obs_mixed !== 1'b0 || (exp_valid && obs_data !== exp_data)) begin
        fails++; $display("FAIL overrun_seq %s", cyc_str());
      end
      if (obs_cap) begin caps++; if (caps == 3) c3 = i; end
      if (obs_ovr && rise < 0) rise = i;
      if (obs_valid && i >= 16) got.push_back(obs_data);
    end
    ok = (got.size() == 8);
    for (int k = 0; k < 8; k++)
      if (ok && got[k] !== ((k < 4) ? DW'(sum_a - DW'(k)) : DW'(sum_b - DW'(k - 4)))) ok = 1'b0;
    checks++; if (!ok) begin fails++; $display("FAIL ovr_frames got %p want only A sum %h and B sum %h frames", got, sum_a, sum_b); end
    checks++; if (c3 < 0 || rise != c3 + 1) begin fails++; $display("FAIL ovr_rise got cycle %0d want %0d", rise, c3 + 1); end
    checks++; if (overrun !== 1'b1) begin fails++; $display("FAIL ovr_sticky got %b want 1", overrun); end
  endtask

  task automatic test_cap_final();
    logic [DW-1:0] w[8];
    logic [DW-1:0] got[$];
    int at[$];
    logic [DW-1:0] sum_b = '0;
    for (int i = 0; i < 8; i++) w[i] = DW'($urandom);
    for (int i = 4; i < 8; i++) sum_b += w[i];
    for (int i = 0; i < 20; i++) begin
      cycle(i < 8, (i < 8) ? w[i % 8] : '0, 1'b1);
      checks++;
      if (obs_valid !== exp_valid || obs_last !== exp_last || obs_ovr !== exp_ovr || obs_cap !== exp_cap ||
          obs_mixed !== 1'b0 || (exp_valid && obs_data !== exp_data)) begin
        fails++; $display("FAIL cap_final %s", cyc_str());
      end
      if (obs_valid) begin got.push_back(obs_data); at.push_back(i); end
    end
    checks++;
    if (got.size() != 8 || at[4] != at[3] + 1 || got[4] !== sum_b) begin
      fails++; $display("FAIL capfin_next got %0d words, B word0 %h want 8 words, B word0 %h right after A last", got.size(),
                        (got.size() > 4) ? got[4] : '0, sum_b);
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] w[4];
    bit hit = 1'b0;
    int seen = 0;
    for (int i = 0; i < 4; i++) w[i] = DW'($urandom);
    for (int i = 0; i < 12; i++) begin
      if (cur.size() == 2) begin hit = 1'b1; break; end
      cycle(i < 4, (i < 4) ? w[i] : '0, 1'b1);
      checks++;
      if (obs_valid !== exp_valid || obs_last !== exp_last || obs_ovr !== exp_ovr || obs_cap !== exp_cap ||
          obs_mixed !== 1'b0 || (exp_valid && obs_data !== exp_data)) begin
        fails++; $display("FAIL reset_mid_pre %s", cyc_str());
      end
    end
    checks++; if (!hit) begin fails++; $display("FAIL rmid_reach got no word 2 want word 2 within 12 cycles"); end
    #2 rst = 1'b0;
    #1;
    checks++; if (s_valid !== 1'b0) begin fails++; $display("FAIL rmid_valid got %b want 0", s_valid); end
    checks++; if (overrun !== 1'b0) begin fails++; $display("FAIL rmid_overrun got %b want 0", overrun); end
    model_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle(i >= 8 && i < 12, (i >= 8 && i < 12) ? w[i - 8] : '0, 1'b1);
      checks++;
      if (obs_valid !== exp_valid || obs_last !== exp_last || obs_ovr !== exp_ovr || obs_cap !== exp_cap ||
          obs_mixed !== 1'b0 || (exp_valid && obs_data !== exp_data)) begin
        fails++; $display("FAIL reset_mid_post %s", cyc_str());
      end
      if (i < 12 && obs_valid) seen++;
    end
    checks++; if (seen != 0) begin fails++; $display("FAIL rmid_quiet got %0d valid cycles want 0", seen); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 9) < 6, DW'($urandom), $urandom_range(0, 9) < 7);
      checks++;
      if (obs_valid !== exp_valid || obs_last !== exp_last || obs_ovr !== exp_ovr || obs_cap !== exp_cap ||
          obs_mixed !== 1'b0 || (exp_valid && obs_data !== exp_data)) begin
        fails++; $display("FAIL random %s", cyc_str());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_frame();
    test_backpressure();
    test_back_to_back();
    test_overrun();
    test_cap_final();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
